// File: rtl/memout_page_reader_pkg.sv
// Shared sizing constants and FSM state type for the output-page reader.
package memout_page_reader_pkg;

  localparam int DATA_W     = 32;
  localparam int PAGE_DEPTH = 32;
  localparam int IDX_W      = 5;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/memout_page_reader_fifo.sv
// Synchronous first-word fall-through skid FIFO with an occupancy count.
module stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  import memout_page_reader_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign do_wr = wr_en_i && (count_q != CNT_W'(DEPTH));
  assign do_rd = rd_en_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: rtl/memout_page_reader.sv
// Reads a completed page out of the two-page output BRAM and streams it
// with valid/ready, tagging the final beat and the page BX.
module memout_page_reader #(
  parameter int DATA_W     = memout_page_reader_pkg::DATA_W,
  parameter int PAGE_DEPTH = memout_page_reader_pkg::PAGE_DEPTH,
  parameter int RD_LATENCY = memout_page_reader_pkg::RD_LATENCY,
  parameter int FIFO_DEPTH = memout_page_reader_pkg::FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  bx_in,
  input  logic                        bx_valid,
  input  logic [$clog2(PAGE_DEPTH):0] nent_in,
  output logic                        mem_enb,
  output logic [$clog2(PAGE_DEPTH):0] mem_readaddr,
  input  logic [DATA_W-1:0]           mem_dout,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [1:0]                  out_bx,
  output logic                        busy,
  output logic                        overrun
);
  import memout_page_reader_pkg::*;

  localparam int PG_IDX_W = $clog2(PAGE_DEPTH);
  localparam int CNT_W    = PG_IDX_W + 1;
  localparam int OCC_W    = $clog2(RD_LATENCY + 1);
  localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);

  state_e                state_q;
  logic                  page_q;
  logic [PG_IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]      count_q;
  logic [1:0]            bx_q;
  logic                  overrun_q;
  logic [RD_LATENCY-1:0] vld_q, last_q;

  logic [CNT_W-1:0]  nent_sat;
  logic [OCC_W-1:0]  inflight;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [DATA_W:0]   fifo_rd;
  logic fifo_valid, credit, issue, idx_last, fire, last_hs, accept, drop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(vld_q[i]);
    end
  end

  // Reads in flight are counted against FIFO space so returning data always fits.
  assign credit   = (int'(inflight) + int'(fifo_cnt)) < FIFO_DEPTH;
  assign issue    = !reset && (state_q == READ) && credit;
  assign idx_last = ({1'b0, idx_q} == (count_q - 1'b1));
  assign nent_sat = (nent_in > CNT_W'(PAGE_DEPTH)) ? CNT_W'(PAGE_DEPTH) : nent_in;

  assign fire    = out_valid && out_ready;
  assign last_hs = fire && fifo_rd[DATA_W];
  assign accept  = bx_valid && (nent_in != '0) &&
                   ((state_q == IDLE) || ((state_q == DRAIN) && last_hs));
  assign drop    = bx_valid && ((state_q == READ) || ((state_q == DRAIN) && !last_hs));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      page_q    <= 1'b0;
      idx_q     <= '0;
      count_q   <= '0;
      bx_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        page_q  <= bx_in[0];
        idx_q   <= '0;
        count_q <= nent_sat;
        bx_q    <= bx_in;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= READ;
        end
        READ: begin
          if (issue) begin
            idx_q <= idx_q + 1'b1;
            if (idx_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs) state_q <= accept ? READ : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid/last pipeline matching the BRAM latency; cleared on reset so
  // data still returning from an aborted page is never captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= issue;
      last_q[0] <= issue && idx_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (vld_q[RD_LATENCY-1]),
    .wr_data_i ({last_q[RD_LATENCY-1], mem_dout}),
    .rd_en_i   (fire),
    .rd_data_o (fifo_rd),
    .valid_o   (fifo_valid),
    .count_o   (fifo_cnt)
  );

  assign mem_enb      = issue;
  assign mem_readaddr = {page_q, idx_q};
  assign out_valid    = fifo_valid && !reset;
  assign out_data     = reset ? '0 : fifo_rd[DATA_W-1:0];
  assign out_last     = out_valid && fifo_rd[DATA_W];
  assign out_bx       = reset ? 2'b00 : bx_q;
  assign busy         = !reset && (state_q != IDLE);
  assign overrun      = overrun_q && !reset;

endmodule

// File: tb/tb_memout_page_reader.sv
// Bench for memout_page_reader: BRAM model, beat/read-address scoreboard,
// directed timing sequences, a vector table and randomized pages.
module tb_memout_page_reader;

  logic        clk, reset, bx_valid, mem_enb, out_valid, out_ready, out_last, busy, overrun;
  logic [1:0]  bx_in, out_bx;
  logic [5:0]  nent_in, mem_readaddr;
  logic [31:0] mem_dout, out_data;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  bx;
  } beat_t;

  typedef struct {
    logic [1:0] bx;
    logic [5:0] nent;
    int         rmode;
    int         exp_beats;
    int         exp_base;
  } vec_t;

  beat_t       expq[$];
  logic [5:0]  addrq[$];
  logic [31:0] bram [64];
  logic [31:0] p0, p1;
  int n_cmp, n_bad, issued, hs, pg_beats, first_addr, ready_mode;

  memout_page_reader dut (
    .clk          (clk),
    .reset        (reset),
    .bx_in        (bx_in),
    .bx_valid     (bx_valid),
    .nent_in      (nent_in),
    .mem_enb      (mem_enb),
    .mem_readaddr (mem_readaddr),
    .mem_dout     (mem_dout),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_bx       (out_bx),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Two-cycle BRAM: request seen mid-cycle, data valid two cycles later.
  initial begin
    logic       en_s;
    logic [5:0] a_s;
    p0 = '0;
    p1 = '0;
    forever begin
      @(negedge clk);
      en_s = mem_enb;
      a_s  = mem_readaddr;
      @(posedge clk);
      p0 <= en_s ? bram[a_s] : 32'hdead_beef;
      p1 <= p0;
    end
  end
  assign mem_dout = p1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        3:       out_ready = 1'b0;
        4:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected stream of an accepted page: entries 0..min(n,32)-1 of page bx[0].
  task automatic push_page(input logic [1:0] bx, input logic [5:0] n);
    int         eff;
    logic [5:0] a;
    eff = (n > 6'd32) ? 32 : int'(n);
    for (int i = 0; i < eff; i++) begin
      a = {bx[0], 5'(i)};
      expq.push_back('{data: bram[a], last: (i == eff - 1), bx: bx});
      addrq.push_back(a);
    end
  endtask

  task automatic send_page(input logic [1:0] bx, input logic [5:0] n);
    @(posedge clk);
    #1;
    bx_valid = 1'b1;
    bx_in    = bx;
    nent_in  = n;
    push_page(bx, n);
    @(posedge clk);
    #1;
    bx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((expq.size() != 0 || addrq.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      fail_now("idle_timeout", 64'(expq.size()), 64'd0);
      expq.delete();
      addrq.delete();
    end
    @(negedge clk);
    check("busy_after_page", 64'(busy), 64'd0);
  endtask

  // Scoreboard: read order and credit, beat contents, hold stability, stale beats.
  initial begin
    logic        stall_q;
    logic [34:0] held;
    logic [5:0]  ea;
    beat_t       e;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_q = 1'b0;
      end else begin
        if (mem_enb) begin
          issued++;
          check("read_credit", 64'((issued - hs) <= 4), 64'd1);
          if (first_addr < 0) first_addr = int'(mem_readaddr);
          if (addrq.size() == 0) begin
            fail_now("spurious_read", 64'(mem_readaddr), 64'd0);
          end else begin
            ea = addrq.pop_front();
            check("read_addr", 64'(mem_readaddr), 64'(ea));
          end
        end
        if (stall_q) begin
          check("hold_stable", 64'({out_valid, out_data, out_last, out_bx}), 64'({1'b1, held}));
        end
        if (out_valid) begin
          if (expq.size() == 0) begin
            fail_now("stale_beat", 64'(out_data), 64'd0);
          end else if (out_ready) begin
            e = expq.pop_front();
            check("beat_data", 64'(out_data), 64'(e.data));
            check("beat_last", 64'(out_last), 64'(e.last));
            check("beat_bx", 64'(out_bx), 64'(e.bx));
            hs++;
            pg_beats++;
          end
        end
        stall_q = out_valid && !out_ready;
        held    = {out_data, out_last, out_bx};
      end
    end
  end

  initial begin
    vec_t       vt[8];
    logic [5:0] n;
    logic [1:0] b;
    bx_valid = 1'b0; bx_in = '0; nent_in = '0; reset = 1'b1; ready_mode = 0;
    n_cmp = 0; n_bad = 0; issued = 0; hs = 0; pg_beats = 0; first_addr = -1;
    foreach (bram[i]) bram[i] = $urandom;

    vt[0] = '{2'd0, 6'd1,  0, 1,  0};
    vt[1] = '{2'd3, 6'd32, 1, 32, 32};
    vt[2] = '{2'd2, 6'd40, 2, 32, 0};
    vt[3] = '{2'd1, 6'd0,  0, 0,  0};
    vt[4] = '{2'd1, 6'd17, 4, 17, 32};
    vt[5] = '{2'd0, 6'd63, 1, 32, 0};
    vt[6] = '{2'd3, 6'd31, 2, 31, 32};
    vt[7] = '{2'd2, 6'd2,  1, 2,  0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({mem_enb, out_valid, out_last, busy, overrun, out_data, out_bx}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single page of 5 with ready held high: exact cycle timing.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      bx_valid = (k == 0);
      bx_in    = 2'd2;
      nent_in  = 6'd5;
      if (k == 0) push_page(2'd2, 6'd5);
      @(negedge clk);
      check($sformatf("t5_enb_c%0d", k),   64'(mem_enb),   64'(k >= 1 && k <= 5));
      check($sformatf("t5_valid_c%0d", k), 64'(out_valid), 64'(k >= 4 && k <= 8));
      check($sformatf("t5_last_c%0d", k),  64'(out_last),  64'(k == 8));
      check($sformatf("t5_busy_c%0d", k),  64'(busy),      64'(k >= 1 && k <= 8));
    end
    bx_valid = 1'b0;
    wait_idle();

    // Event during READ is dropped; event on the last handshake is accepted.
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      #1;
      bx_valid = 1'b0;
      if (k == 0) begin bx_valid = 1'b1; bx_in = 2'd1; nent_in = 6'd5; push_page(2'd1, 6'd5); end
      if (k == 2) begin bx_valid = 1'b1; bx_in = 2'd2; nent_in = 6'd7; end
      if (k == 8) begin bx_valid = 1'b1; bx_in = 2'd3; nent_in = 6'd3; push_page(2'd3, 6'd3); end
      @(negedge clk);
      if (k == 1) check("ovr_before_drop", 64'(overrun), 64'd0);
      if (k == 3) check("ovr_after_drop", 64'(overrun), 64'd1);
      if (k == 8) check("ovr_last_hs", 64'({out_valid, out_ready, out_last}), 64'h7);
      if (k == 9) check("ovr_next_page", 64'({busy, mem_enb, overrun}), 64'h7);
    end
    bx_valid = 1'b0;
    wait_idle();

    // Reset mid-page aborts it; nothing stale may follow.
    send_page(2'd0, 6'd20);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    expq.delete();
    addrq.delete();
    issued = 0;
    hs = 0;
    @(negedge clk);
    check("reset_mid_outputs", 64'({mem_enb, out_valid, out_last, busy, overrun, out_data, out_bx}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_idle", 64'({busy, overrun}), 64'd0);

    // Long back-pressure in the middle of a full page.
    pg_beats = 0;
    send_page(2'd3, 6'd32);
    repeat (6) @(posedge clk);
    ready_mode = 3;
    repeat (20) @(posedge clk);
    ready_mode = 0;
    wait_idle();
    check("stall_beats", 64'(pg_beats), 64'd32);

    foreach (vt[i]) begin
      ready_mode = vt[i].rmode;
      pg_beats   = 0;
      first_addr = -1;
      send_page(vt[i].bx, vt[i].nent);
      wait_idle();
      check($sformatf("vec%0d_beats", i), 64'(pg_beats), 64'(vt[i].exp_beats));
      if (vt[i].exp_beats > 0) check($sformatf("vec%0d_base", i), 64'(first_addr), 64'(vt[i].exp_base));
    end

    for (int r = 0; r < 25; r++) begin
      ready_mode = ($urandom_range(0, 1) == 1) ? 2 : 4;
      n = 6'($urandom_range(0, 40));
      b = 2'($urandom_range(0, 3));
      pg_beats = 0;
      send_page(b, n);
      wait_idle();
      check($sformatf("rand%0d_beats", r), 64'(pg_beats), 64'((n > 6'd32) ? 32 : int'(n)));
    end

    check("overrun_final", 64'(overrun), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memout_page_reader.md
MEMOUT_PAGE_READER -- requirements
Module: memout_page_reader

Interface
REQ-001 SHALL have parameter DATA_W, 32, BRAM word and stream width.
REQ-002 SHALL have parameter PAGE_DEPTH, 32, entries per page; page address width IDX_W = 5.
REQ-003 SHALL have parameter RD_LATENCY, 2, BRAM read latency in cycles (HIGH_PERFORMANCE output register).
REQ-004 SHALL have parameter FIFO_DEPTH, 4, output skid FIFO depth, at least RD_LATENCY+2.
REQ-005 SHALL have port clk, input, 1, the clock; rising edge only.
REQ-006 SHALL have port reset, input, 1, the reset; synchronous, active-high.
REQ-007 SHALL have port bx_in, input, 2, the BX of the page the upstream stage just completed.
REQ-008 SHALL have port bx_valid, input, 1, a one-cycle pulse marking that the page is complete.
REQ-009 SHALL have port nent_in, input, 6, the entry count of that page, 0..32; sampled with bx_valid.
REQ-010 SHALL have port mem_enb, output, 1, the two-page output BRAM read enable.
REQ-011 SHALL have port mem_readaddr, output, 6, the read address {page, idx[4:0]}.
REQ-012 SHALL have port mem_dout, input, DATA_W, the BRAM read data.
REQ-013 SHALL have port out_data, output, DATA_W, the stream data.
REQ-014 SHALL have port out_valid, output, 1, the stream valid.
REQ-015 SHALL have port out_ready, input, 1, the stream ready.
REQ-016 SHALL have port out_last, output, 1, high on the final beat of a page.
REQ-017 SHALL have port out_bx, output, 2, the BX of the page being streamed.
REQ-018 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-019 SHALL have port overrun, output, 1, a sticky flag for a dropped bx_valid.

Function
REQ-020 SHALL implement FSM states IDLE, READ and DRAIN.
REQ-021 IDLE with bx_valid and nent_in>0 SHALL latch page=bx_in[0], count=nent_in and bx=bx_in, then go to READ.
REQ-022 IDLE with bx_valid and nent_in=0 SHALL produce no beats and no reads, and SHALL remain in IDLE.
REQ-023 In READ, a read SHALL issue (mem_enb=1, idx incrementing from 0) only when outstanding reads + FIFO occupancy < FIFO_DEPTH.
REQ-024 The FIFO SHALL never overflow.
REQ-025 mem_enb SHALL be 0 whenever no read issues; mem_readaddr is then don't-care.
REQ-026 Data from a read issued at cycle t SHALL be written into the FIFO at t+RD_LATENCY.
REQ-027 With out_ready held at 1, that beat SHALL present on out_valid at t+RD_LATENCY+1.
REQ-028 After the issue with idx=count-1, the FSM SHALL go to DRAIN.
REQ-029 DRAIN SHALL return to IDLE on the cycle after the out_last beat handshakes (out_valid and out_ready both 1).
REQ-030 Beats SHALL leave in address order; out_data, out_last and out_bx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 out_last SHALL be 1 only on beat count-1.
REQ-032 bx_valid in READ, or in DRAIN except on the out_last handshake cycle, SHALL set overrun and drop the event.
REQ-033 bx_valid on the out_last handshake cycle SHALL be accepted, and READ SHALL start the next cycle.
REQ-034 idx SHALL never exceed count-1; nent_in values above 32 SHALL saturate to 32.

Reset
REQ-035 While reset=1, the FSM SHALL be IDLE, the FIFO empty, and in-flight reads discarded.
REQ-036 While reset=1, mem_enb, out_valid, out_last, busy and overrun SHALL be 0, and out_data and out_bx SHALL be 0.
REQ-037 Reset asserted mid-page SHALL abort the page; data returning after reset deasserts SHALL be ignored.

Structure
REQ-038 A shared package SHALL hold DATA_W, PAGE_DEPTH, IDX_W, RD_LATENCY, FIFO_DEPTH and the state enum.
REQ-039 A single sub-module, stream_fifo (synchronous, first-word fall-through, with count output), SHALL implement the skid FIFO.
REQ-040 A RD_LATENCY-deep valid shift register SHALL track outstanding reads.

Verification
REQ-041 bx_valid at c0 with bx_in=2 and nent_in=5, out_ready=1 -> mem_enb at c1..c5 with addr 0..4, out_valid at c4..c8, out_last at c8, out_bx=2, busy low at c9.
REQ-042 bx_in=3 and nent_in=32, out_ready toggling 1/0 -> 32 beats in order from addr 32..63, no FIFO overflow, out_last on beat 31.
REQ-043 nent_in=0 -> no mem_enb, no out_valid, busy stays 0.
REQ-044 bx_valid during READ -> overrun=1 and the current page completes unchanged; bx_valid on the out_last handshake cycle -> the next page starts with overrun unchanged.
REQ-045 out_ready=0 held for 20 cycles mid-page -> at most 4 beats buffered, out_data stable, and the stream resumes with no loss.
REQ-046 reset pulse mid-page -> outputs 0 next cycle and no stale beat afterwards; a new page then streams correctly.
